// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the 32-bit combinational ALU.
// Accepts one request at a time, decodes ALUOp/funct into ALU_control and
// bonus_control, holds the ALU inputs in registers, captures the ALU result
// and returns it on a valid/ready response channel. MUL is held MUL_LAT
// cycles before capture.
// Optional build macro: ALU_ISSUE_OVERLAP_EN lets a new request be accepted
// in the same cycle as the response handshake (RESP -> EXEC directly).
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// EXEC  | ALU inputs driven, capture (or start MUL wait)
// MULW  | MUL wait, counter counting down to zero
// RESP  | response valid, everything held until rsp_ready

module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        alu_rst_n,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_control,
  output logic [2:0]  alu_bonus,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULW = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // MUL_LAT=1 captures straight from EXEC; larger values count down in MULW.
  localparam bit         MUL_MULTI    = (MUL_LAT > 1);
  localparam logic [3:0] MUL_CNT_INIT = MUL_MULTI ? 4'(MUL_LAT - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        alu_rst_n_q;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [2:0]  bonus_q, bonus_d;
  logic        mul_q, mul_d;
  logic        addsub_q, addsub_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_ill_q, rsp_ill_d;

  logic        dec_legal;
  logic [3:0]  dec_ctrl;
  logic [2:0]  dec_bonus;
  logic        dec_mul;
  logic        dec_addsub;
  logic        accept;
  logic        load_req;
  logic        capture;

  // Request decode: ALUOp/funct to ALU_control, bonus_control and op flags.
  always_comb begin
    dec_legal  = 1'b1;
    dec_ctrl   = 4'b0000;
    dec_bonus  = 3'b000;
    dec_mul    = 1'b0;
    dec_addsub = 1'b0;
    case (req_aluop)
      3'b000: begin dec_ctrl = 4'b0010; dec_addsub = 1'b1; end
      3'b001: begin dec_ctrl = 4'b0110; dec_addsub = 1'b1; end
      3'b011: dec_ctrl = 4'b0111;
      3'b100: dec_ctrl = 4'b0001;
      3'b101: begin
        dec_ctrl  = 4'b0111;
        dec_bonus = req_funct[2:0];
        case (req_funct[2:0])
          3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100: dec_legal = 1'b1;
          default: dec_legal = 1'b0;
        endcase
      end
      3'b010: begin
        case (req_funct)
          6'b100000: begin dec_ctrl = 4'b0010; dec_addsub = 1'b1; end
          6'b100010: begin dec_ctrl = 4'b0110; dec_addsub = 1'b1; end
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b100111: dec_ctrl = 4'b1100;
          6'b101010: dec_ctrl = 4'b0111;
          6'b000000: dec_ctrl = 4'b1000;
          6'b000010: dec_ctrl = 4'b1001;
          6'b011000: begin dec_ctrl = 4'b0011; dec_mul = 1'b1; end
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef ALU_ISSUE_OVERLAP_EN
  assign req_ready = rst_n && ((state_q == ST_IDLE) ||
                               ((state_q == ST_RESP) && rsp_ready));
`else
  assign req_ready = rst_n && (state_q == ST_IDLE);
`endif

  assign accept = req_valid && req_ready;

  // Next-state logic; flags which datapath action happens this cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_req = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load_req = 1'b1;
          state_d  = dec_legal ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        if (mul_q && MUL_MULTI) begin
          cnt_d   = MUL_CNT_INIT;
          state_d = ST_MULW;
        end else begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_MULW: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
`ifdef ALU_ISSUE_OVERLAP_EN
          if (accept) begin
            load_req = 1'b1;
            state_d  = dec_legal ? ST_EXEC : ST_RESP;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: load ALU inputs on legal accept, build responses otherwise.
  always_comb begin
    src1_d       = src1_q;
    src2_d       = src2_q;
    ctrl_d       = ctrl_q;
    bonus_d      = bonus_q;
    mul_d        = mul_q;
    addsub_d     = addsub_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_ill_d    = rsp_ill_q;
    if (load_req && dec_legal) begin
      src1_d   = req_src1;
      src2_d   = req_src2;
      ctrl_d   = dec_ctrl;
      bonus_d  = dec_bonus;
      mul_d    = dec_mul;
      addsub_d = dec_addsub;
    end
    if (load_req && !dec_legal) begin
      rsp_result_d = 32'd0;
      rsp_zero_d   = 1'b0;
      rsp_ovf_d    = 1'b0;
      rsp_ill_d    = 1'b1;
    end
    if (capture) begin
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      rsp_ovf_d    = addsub_q && alu_overflow;
      rsp_ill_d    = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      alu_rst_n_q  <= 1'b0;
      src1_q       <= 32'd0;
      src2_q       <= 32'd0;
      ctrl_q       <= 4'd0;
      bonus_q      <= 3'd0;
      mul_q        <= 1'b0;
      addsub_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_rst_n_q  <= 1'b1;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      ctrl_q       <= ctrl_d;
      bonus_q      <= bonus_d;
      mul_q        <= mul_d;
      addsub_q     <= addsub_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_ill_q    <= rsp_ill_d;
    end
  end

  assign alu_rst_n    = alu_rst_n_q;
  assign alu_src1     = src1_q;
  assign alu_src2     = src2_q;
  assign alu_control  = ctrl_q;
  assign alu_bonus    = bonus_q;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_illegal  = rsp_ill_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 32-bit ALU interface. Accepts one ALU request at a time over a valid/ready handshake.
- Decodes ALUOp/funct into the ALU's 4-bit ALU_control and 3-bit bonus_control codes, and holds operands and controls stable in registers.
- Captures result, zero and overflow from the combinational ALU, then returns them on a valid/ready response channel.
- Sits between the CPU decode stage and the ALU; MUL is treated as multi-cycle.

Parameters:
- MUL_LAT, 2, cycles the ALU inputs are held for MUL before capture (legal range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_aluop  input  3  ALUOp from main control.
- req_funct  input  6  instruction funct field.
- req_src1  input  32  operand 1.
- req_src2  input  32  operand 2.
- alu_rst_n  output  1  drives ALU rst_n.
- alu_src1  output  32  ALU src1.
- alu_src2  output  32  ALU src2.
- alu_control  output  4  ALU_control.
- alu_bonus  output  3  bonus_control.
- alu_result  input  32  ALU result.
- alu_zero  input  1  ALU zero.
- alu_overflow  input  1  ALU overflow.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  32  captured result.
- rsp_zero  output  1  captured zero.
- rsp_overflow  output  1  captured overflow (ADD/SUB only).
- rsp_illegal  output  1  request did not decode.

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst_n.
- While rst_n is low, at the next edge:
  - state=IDLE.
  - alu_src1, alu_src2, alu_control, alu_bonus all 0.
  - All rsp_* outputs 0.
  - alu_rst_n=0.
  - req_ready is forced 0 while rst_n is low.
- alu_rst_n is rst_n registered once, so it rises one cycle after reset release.
- Decode, by req_aluop:
  - 000: ADD 0010.
  - 001: SUB 0110.
  - 011: SLT 0111/000.
  - 100: OR 0001.
  - 101: set-compare; control 0111, bonus=funct[2:0]. Legal funct[2:0] are 000, 001, 010, 011, 110, 100; anything else is illegal.
  - 010: R-type by funct:
    - 100000 ADD 0010; 100010 SUB 0110.
    - 100100 AND 0000; 100101 OR 0001; 100111 NOR 1100.
    - 101010 SLT 0111/000.
    - 000000 SLL 1000; 000010 SRL 1001.
    - 011000 MUL 0011.
    - any other funct is illegal.
  - 110, 111: illegal.
  - alu_bonus=000 for every non-0111 code.
- FSM states: IDLE, EXEC, MULW, RESP. req_ready=1 only in IDLE.
- IDLE:
  - On req_valid&&req_ready, legal request: load alu_* registers, go EXEC.
  - Illegal request: alu_* registers unchanged; load rsp_result=0, rsp_zero=0, rsp_overflow=0, rsp_illegal=1; go RESP.
- EXEC:
  - Non-MUL: capture rsp_result=alu_result, rsp_zero=alu_zero, rsp_illegal=0, and rsp_overflow=alu_overflow if the op is ADD/SUB, else 0. Go RESP.
  - MUL with MUL_LAT=1: capture as above, go RESP.
  - MUL with MUL_LAT>1: load a counter with MUL_LAT-2, go MULW.
- MULW: decrement the counter each cycle; capture and go RESP when it reaches 0. Total hold is MUL_LAT cycles.
- RESP:
  - rsp_valid=1. All rsp_* and alu_* outputs held stable while rsp_ready=0.
  - On rsp_ready: go IDLE, rsp_valid drops next cycle.
- Latency, counted in edges after the accepting edge:
  - Legal non-MUL: rsp_valid is high 2 edges later.
  - MUL: MUL_LAT+1 edges later.
  - Illegal: 1 edge later.
- ALU inputs change only on request acceptance; they are held after the response.
- Reset mid-operation (any state): the outstanding request is discarded with no response; outputs return to reset values.
- A request presented while req_ready=0 is not accepted and must be held by the source.

Optional Feature:
- Macro ALU_ISSUE_OVERLAP_EN.
- Defined:
  - In RESP, req_ready = rsp_ready.
  - A request accepted in the same cycle as the response handshake is decoded and the FSM goes directly RESP->EXEC (or RESP->RESP if illegal).
  - Sustained non-MUL throughput is one result every 2 cycles.
- Undefined: req_ready only in IDLE, giving one result every 3 cycles minimum.

Test Plan:
1. Reset 2 cycles, then aluop=010 funct=100000 src1=5 src2=7 -> alu_control=0010, alu_bonus=000; rsp_valid 2 edges after accept; rsp_result=12, rsp_zero=0, rsp_illegal=0.
2. aluop=000 src1=0x7FFFFFFF src2=1 -> rsp_result=0x80000000, rsp_overflow=1. Then aluop=001 src1=src2=0x10 -> control 0110, rsp_result=0, rsp_zero=1, rsp_overflow=0.
3. aluop=101 funct=000010 src1=3 src2=3 -> control 0111, bonus 010, rsp_result=1. Repeat with funct=000001 -> rsp_result=0.
4. MUL (aluop=010 funct=011000) src1=6 src2=7, MUL_LAT=2 -> alu_control=0011 stable 2 cycles; rsp_valid 3 edges after accept; rsp_result=42.
5. aluop=110, then aluop=101 funct=000111 -> rsp_valid 1 edge after accept, rsp_illegal=1, rsp_result=0, alu_control and alu_src* unchanged from the previous request.
6. Hold rsp_ready=0 for 4 cycles in RESP -> rsp_* stable, req_ready=0. Then assert rst_n=0 during EXEC of a new request -> no response, all outputs 0 next edge, alu_rst_n=0.
